// File: rtl/vga_grid_ram.sv
// Dual-port grid RAM with built-in clear sweep; game logic on port A, VGA fetch on port B.
// Define VGA_RAM_FWD_EN to forward a same-cycle write from one port to the other port's read.
module vga_grid_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4096,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_we,
    output logic [DATA_W-1:0] a_rdata,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic              b_we,
    output logic [DATA_W-1:0] b_rdata,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              a_in, b_in, same_addr, a_wr, b_wr;
    logic [IDX_W-1:0]  a_idx, b_idx;
    logic [DATA_W-1:0] a_old, b_old, a_rd_next, b_rd_next;

    // Port B loses a write that collides with port A, so at most one port stores per address.
    always_comb begin
        a_in      = {1'b0, a_addr} < DEPTH_W;
        b_in      = {1'b0, b_addr} < DEPTH_W;
        a_idx     = a_addr[IDX_W-1:0];
        b_idx     = b_addr[IDX_W-1:0];
        same_addr = (a_addr == b_addr);
        a_wr      = a_we && a_in && !busy;
        b_wr      = b_we && b_in && !busy && !(a_wr && same_addr);
        a_old     = mem[a_idx];
        b_old     = mem[b_idx];

        a_rd_next = a_old;
        if (busy || !a_in)
            a_rd_next = CLEAR_VAL;
        else if (a_wr)
            a_rd_next = a_wdata;
`ifdef VGA_RAM_FWD_EN
        else if (b_wr && same_addr)
            a_rd_next = b_wdata;
`endif

        b_rd_next = b_old;
        if (busy || !b_in)
            b_rd_next = CLEAR_VAL;
        else if (b_wr)
            b_rd_next = b_wdata;
`ifdef VGA_RAM_FWD_EN
        else if (a_wr && same_addr)
            b_rd_next = a_wdata;
`endif
    end

    // Storage has no reset; the sweep is what restores CLEAR_VAL.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[ptr] <= CLEAR_VAL;
        end else begin
            if (a_wr)
                mem[a_idx] <= a_wdata;
            if (b_wr)
                mem[b_idx] <= b_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            ptr      <= '0;
            busy     <= 1'b1;
            clr_done <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rdata <= a_rd_next;
            b_rdata <= b_rd_next;
            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (ptr == LAST_PTR) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                DONE: begin
                    clr_done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_grid_ram.sv
// Randomized bench for vga_grid_ram against an array-based model of the RAM and its clear sweep.
// Expectations follow VGA_RAM_FWD_EN when the macro is defined.
module tb_vga_grid_ram;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 256;
    localparam logic [DATA_W-1:0] CV = 8'h3C;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
    logic [DATA_W-1:0] a_wdata = '0, b_wdata = '0;
    logic              a_we = 1'b0, b_we = 1'b0, clr_req = 1'b0;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic              busy, clr_done;

    vga_grid_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLEAR_VAL(CV)) dut (
        .clk(clk), .rst(rst),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_we(a_we), .a_rdata(a_rdata),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_we(b_we), .b_rdata(b_rdata),
        .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] mem_m [DEPTH];
    bit m_busy      = 1'b1;
    int m_cnt       = DEPTH;
    bit m_prev_done = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] oldWord(input logic [ADDR_W-1:0] addr);
        if (addr < DEPTH)
            return mem_m[addr[7:0]];
        return CV;
    endfunction

    function automatic logic [ADDR_W-1:0] randAddr();
        if ($urandom_range(0, 1) == 0)
            return ADDR_W'($urandom_range(0, 15));
        return ADDR_W'($urandom_range(0, DEPTH + 20));
    endfunction

    // One clock of stimulus; the model predicts the outputs seen just after the edge.
    task automatic applyStimulus(input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] aw, input logic awe,
                                 input logic [ADDR_W-1:0] bb, input logic [DATA_W-1:0] bw, input logic bwe,
                                 input logic creq);
        logic [DATA_W-1:0] ea, eb, a_prev, b_prev;
        bit ed, aeff, beff;
        a_addr = aa; a_wdata = aw; a_we = awe;
        b_addr = bb; b_wdata = bw; b_we = bwe;
        clr_req = creq;
        ed = 1'b0;
        if (m_busy) begin
            ea = CV;
            eb = CV;
            m_cnt--;
            if (m_cnt == 0) begin
                for (int i = 0; i < DEPTH; i++) mem_m[i] = CV;
                m_busy = 1'b0;
                ed = 1'b1;
            end
        end else begin
            a_prev = oldWord(aa);
            b_prev = oldWord(bb);
            aeff = awe && (aa < DEPTH);
            beff = bwe && (bb < DEPTH) && !(aeff && aa == bb);
            if (aa >= DEPTH)            ea = CV;
            else if (aeff)              ea = aw;
`ifdef VGA_RAM_FWD_EN
            else if (beff && bb == aa)  ea = bw;
`endif
            else                        ea = a_prev;
            if (bb >= DEPTH)            eb = CV;
            else if (beff)              eb = bw;
`ifdef VGA_RAM_FWD_EN
            else if (aeff && aa == bb)  eb = aw;
`endif
            else                        eb = b_prev;
            if (aeff) mem_m[aa[7:0]] = aw;
            if (beff) mem_m[bb[7:0]] = bw;
            if (creq && !m_prev_done) begin
                m_busy = 1'b1;
                m_cnt  = DEPTH;
            end
        end
        m_prev_done = ed;
        @(posedge clk);
        #1;
        checkOutput("busy", 32'(busy), 32'(m_busy));
        checkOutput("clr_done", 32'(clr_done), 32'(ed));
        checkOutput("a_rdata", 32'(a_rdata), 32'(ea));
        checkOutput("b_rdata", 32'(b_rdata), 32'(eb));
    endtask

    task automatic idleStep(input logic [ADDR_W-1:0] aa, input logic [ADDR_W-1:0] bb);
        applyStimulus(aa, 8'h00, 1'b0, bb, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic randomStep(input bit allow_clr);
        applyStimulus(randAddr(), 8'($urandom), 1'($urandom), randAddr(), 8'($urandom), 1'($urandom),
                      allow_clr && ($urandom_range(0, 99) == 0));
    endtask

    // Pulse reset between edges and check the asynchronous reset values.
    task automatic pulseReset();
        rst = 1'b1;
        #2;
        checkOutput("rst_a_rdata", 32'(a_rdata), 32'h0);
        checkOutput("rst_b_rdata", 32'(b_rdata), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h1);
        checkOutput("rst_clr_done", 32'(clr_done), 32'h0);
        m_busy = 1'b1;
        m_cnt = DEPTH;
        m_prev_done = 1'b0;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = CV;
        @(posedge clk);
        #1;
        pulseReset();

        // Initial sweep with idle ports, then a few idle cycles past clr_done.
        for (int i = 0; i < DEPTH + 3; i++) idleStep(ADDR_W'(i % DEPTH), ADDR_W'(7));

        applyStimulus(10'd0, 8'd200, 1'b1, 10'd3, 8'd0, 1'b0, 1'b0);
        idleStep(10'd9, 10'd0);
        applyStimulus(10'd1, 8'd37, 1'b1, 10'd1, 8'd99, 1'b1, 1'b0);
        idleStep(10'd1, 10'd1);
        applyStimulus(10'd5, 8'd10, 1'b1, 10'd2, 8'd0, 1'b0, 1'b0);
        applyStimulus(10'd5, 8'd55, 1'b1, 10'd5, 8'd0, 1'b0, 1'b0);
        idleStep(10'd5, 10'd5);
        applyStimulus(10'(DEPTH), 8'hAA, 1'b1, 10'(DEPTH), 8'h11, 1'b1, 1'b0);
        idleStep(10'(DEPTH), 10'd0);
        idleStep(10'd0, 10'(DEPTH + 1));

        for (int i = 0; i < 400; i++) randomStep(1'b1);

        // Let any sweep started by random traffic finish before the directed clear.
        for (int i = 0; i < DEPTH + 2; i++) idleStep(ADDR_W'(i % DEPTH), ADDR_W'(3));
        for (int i = 0; i < 20; i++) randomStep(1'b0);
        applyStimulus(randAddr(), 8'($urandom), 1'b1, randAddr(), 8'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < 100; i++) randomStep(1'b1);
        pulseReset();
        for (int i = 0; i < DEPTH + 2; i++) randomStep(1'b0);
        for (int i = 0; i < DEPTH; i++) idleStep(ADDR_W'(i), ADDR_W'(DEPTH - 1 - i));
        for (int i = 0; i < 200; i++) randomStep(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
